// File: rtl/pipeline_ctrl.sv
// Osiris I hazard/sequencing controller: stalls, flushes, EX forwarding,
// MEM-stage data access FSM with timeout. Optional PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int REG_WIDTH   = 4,
    parameter int TMO_WIDTH   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] i_rs1_D,
    input  logic [REG_WIDTH-1:0] i_rs2_D,
    input  logic [REG_WIDTH-1:0] i_rs1_EX,
    input  logic [REG_WIDTH-1:0] i_rs2_EX,
    input  logic [REG_WIDTH-1:0] i_rd_EX,
    input  logic [1:0]           i_result_src_EX,
    input  logic                 i_pc_src_EX,
    input  logic [REG_WIDTH-1:0] i_rd_M,
    input  logic                 i_reg_write_M,
    input  logic                 i_mem_req_M,
    input  logic [REG_WIDTH-1:0] i_rd_W,
    input  logic                 i_reg_write_W,
    input  logic                 i_mem_ack,
    output logic                 o_stall_F,
    output logic                 o_stall_D,
    output logic                 o_stall_EX,
    output logic                 o_stall_M,
    output logic                 o_flush_D,
    output logic                 o_flush_EX,
    output logic [1:0]           o_forward_a_EX,
    output logic [1:0]           o_forward_b_EX,
    output logic                 o_mem_req,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [31:0]          o_cnt_mstall,
    output logic [31:0]          o_cnt_lu,
    output logic [31:0]          o_cnt_flush,
    output logic [31:0]          o_cnt_tmo,
`endif
    output logic                 o_mem_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [TMO_WIDTH-1:0] TMO_LIM = TMO_WIDTH'(MEM_TIMEOUT);
    localparam logic [TMO_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [TMO_WIDTH-1:0] CNT_ONE = TMO_WIDTH'(1);

    state_t               state_q, state_d;
    logic [TMO_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 mstall;
    logic                 tmo;
    logic                 mreq;
    logic                 lu;
    logic                 lu_bubble;
    logic                 br_flush;

    // EX operand forwarding; MEM result wins over WB result
    always_comb begin
        o_forward_a_EX = 2'b00;
        o_forward_b_EX = 2'b00;
        if (!rst) begin
            if (i_reg_write_M && i_rd_M != '0 && i_rd_M == i_rs1_EX)
                o_forward_a_EX = 2'b10;
            else if (i_reg_write_W && i_rd_W != '0 && i_rd_W == i_rs1_EX)
                o_forward_a_EX = 2'b01;
            if (i_reg_write_M && i_rd_M != '0 && i_rd_M == i_rs2_EX)
                o_forward_b_EX = 2'b10;
            else if (i_reg_write_W && i_rd_W != '0 && i_rd_W == i_rs2_EX)
                o_forward_b_EX = 2'b01;
        end
    end

    // Load-use detection between EX load and DECODE sources
    always_comb begin
        lu = (i_result_src_EX == 2'b01) && (i_rd_EX != '0) &&
             ((i_rd_EX == i_rs1_D) || (i_rd_EX == i_rs2_D));
    end

    // Memory access FSM next state, request strobe and memory stall
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mstall  = 1'b0;
        tmo     = 1'b0;
        mreq    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_mem_req_M) begin
                        mreq = 1'b1;
                        if (!i_mem_ack) begin
                            mstall  = 1'b1;
                            state_d = S_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                S_WAIT: begin
                    mreq = 1'b1;
                    if (i_mem_ack) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LIM) begin
                        tmo     = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        mstall = 1'b1;
                        if (cnt_q != CNT_MAX)
                            cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stall/flush priority: memory stall, taken branch, load-use
    always_comb begin
        o_stall_F  = 1'b0;
        o_stall_D  = 1'b0;
        o_stall_EX = 1'b0;
        o_stall_M  = 1'b0;
        o_flush_D  = 1'b0;
        o_flush_EX = 1'b0;
        lu_bubble  = 1'b0;
        br_flush   = 1'b0;
        if (rst) begin
            o_flush_D  = 1'b1;
            o_flush_EX = 1'b1;
        end else if (mstall) begin
            o_stall_F  = 1'b1;
            o_stall_D  = 1'b1;
            o_stall_EX = 1'b1;
            o_stall_M  = 1'b1;
        end else if (i_pc_src_EX) begin
            o_flush_D  = 1'b1;
            o_flush_EX = 1'b1;
            br_flush   = 1'b1;
        end else if (lu) begin
            o_stall_F  = 1'b1;
            o_stall_D  = 1'b1;
            o_flush_EX = 1'b1;
            lu_bubble  = 1'b1;
        end
    end

    // FSM state, wait counter and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_mem_req = mreq;
    assign o_mem_err = err_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] pc_mstall_q, pc_mstall_d;
    logic [31:0] pc_lu_q, pc_lu_d;
    logic [31:0] pc_flush_q, pc_flush_d;
    logic [31:0] pc_tmo_q, pc_tmo_d;

    // Saturating event counters
    always_comb begin
        pc_mstall_d = pc_mstall_q;
        pc_lu_d     = pc_lu_q;
        pc_flush_d  = pc_flush_q;
        pc_tmo_d    = pc_tmo_q;
        if (mstall && pc_mstall_q != '1)
            pc_mstall_d = pc_mstall_q + 32'd1;
        if (lu_bubble && pc_lu_q != '1)
            pc_lu_d = pc_lu_q + 32'd1;
        if (br_flush && pc_flush_q != '1)
            pc_flush_d = pc_flush_q + 32'd1;
        if (tmo && pc_tmo_q != '1)
            pc_tmo_d = pc_tmo_q + 32'd1;
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_mstall_q <= '0;
            pc_lu_q     <= '0;
            pc_flush_q  <= '0;
            pc_tmo_q    <= '0;
        end else begin
            pc_mstall_q <= pc_mstall_d;
            pc_lu_q     <= pc_lu_d;
            pc_flush_q  <= pc_flush_d;
            pc_tmo_q    <= pc_tmo_d;
        end
    end

    assign o_cnt_mstall = pc_mstall_q;
    assign o_cnt_lu     = pc_lu_q;
    assign o_cnt_flush  = pc_flush_q;
    assign o_cnt_tmo    = pc_tmo_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: forwarding/hazard vector table
// plus memory wait, timeout, priority and reset-in-wait sequences.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rs1_D, rs2_D, rs1_EX, rs2_EX, rd_EX, rd_M, rd_W;
    logic [1:0] rsrc;
    logic       pc_src, rw_M, rw_W, mem_req_M, mem_ack;
    logic       stall_F, stall_D, stall_EX, stall_M;
    logic       flush_D, flush_EX, mem_req, mem_err;
    logic [1:0] fwd_a, fwd_b;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] cnt_mstall, cnt_lu, cnt_flush, cnt_tmo;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_WIDTH   (4),
        .TMO_WIDTH   (8),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rs1_D         (rs1_D),
        .i_rs2_D         (rs2_D),
        .i_rs1_EX        (rs1_EX),
        .i_rs2_EX        (rs2_EX),
        .i_rd_EX         (rd_EX),
        .i_result_src_EX (rsrc),
        .i_pc_src_EX     (pc_src),
        .i_rd_M          (rd_M),
        .i_reg_write_M   (rw_M),
        .i_mem_req_M     (mem_req_M),
        .i_rd_W          (rd_W),
        .i_reg_write_W   (rw_W),
        .i_mem_ack       (mem_ack),
        .o_stall_F       (stall_F),
        .o_stall_D       (stall_D),
        .o_stall_EX      (stall_EX),
        .o_stall_M       (stall_M),
        .o_flush_D       (flush_D),
        .o_flush_EX      (flush_EX),
        .o_forward_a_EX  (fwd_a),
        .o_forward_b_EX  (fwd_b),
        .o_mem_req       (mem_req),
`ifdef PIPELINE_CTRL_PERF_EN
        .o_cnt_mstall    (cnt_mstall),
        .o_cnt_lu        (cnt_lu),
        .o_cnt_flush     (cnt_flush),
        .o_cnt_tmo       (cnt_tmo),
`endif
        .o_mem_err       (mem_err)
    );

    typedef struct {
        logic [3:0] rs1_D, rs2_D, rs1_EX, rs2_EX, rd_EX;
        logic [1:0] rsrc;
        logic       pc;
        logic [3:0] rd_M;
        logic       rw_M;
        logic [3:0] rd_W;
        logic       rw_W;
        logic [3:0] e_stall;
        logic [1:0] e_flush;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] stalls();
        return {stall_F, stall_D, stall_EX, stall_M};
    endfunction

    function automatic logic [1:0] flushes();
        return {flush_D, flush_EX};
    endfunction

    task automatic clr();
        rs1_D = 0; rs2_D = 0; rs1_EX = 0; rs2_EX = 0; rd_EX = 0;
        rsrc = 0; pc_src = 0; rd_M = 0; rw_M = 0; rd_W = 0; rw_W = 0;
        mem_req_M = 0; mem_ack = 0;
    endtask

    initial begin
        //      rs1D rs2D rs1E rs2E rdE rsrc pc rdM rwM rdW rwW stall flush fa fb
        vt[0]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00};
        vt[1]  = '{0, 0, 5, 0, 0, 2'b00, 0, 5, 1, 5, 1, 4'h0, 2'b00, 2'b10, 2'b00};
        vt[2]  = '{0, 0, 5, 0, 0, 2'b00, 0, 0, 1, 5, 1, 4'h0, 2'b00, 2'b01, 2'b00};
        vt[3]  = '{0, 0, 5, 0, 0, 2'b00, 0, 5, 0, 5, 1, 4'h0, 2'b00, 2'b01, 2'b00};
        vt[4]  = '{0, 0, 7, 5, 0, 2'b00, 0, 5, 1, 7, 1, 4'h0, 2'b00, 2'b01, 2'b10};
        vt[5]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 4'h0, 2'b00, 2'b00, 2'b00};
        vt[6]  = '{1, 3, 0, 0, 3, 2'b01, 0, 0, 0, 0, 0, 4'hC, 2'b01, 2'b00, 2'b00};
        vt[7]  = '{0, 3, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00};
        vt[8]  = '{3, 0, 0, 0, 3, 2'b10, 0, 0, 0, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00};
        vt[9]  = '{9, 2, 0, 0, 9, 2'b01, 0, 0, 0, 0, 0, 4'hC, 2'b01, 2'b00, 2'b00};
        vt[10] = '{0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 4'h0, 2'b11, 2'b00, 2'b00};
        vt[11] = '{4, 0, 0, 0, 4, 2'b01, 1, 0, 0, 0, 0, 4'h0, 2'b11, 2'b00, 2'b00};

        clr();
        rst = 1'b1;
        rd_M = 5; rw_M = 1; rs1_EX = 5; mem_req_M = 1;
        cyc();
        #2;
        chk("rst_stall", 32'(stalls()), 32'h0);
        chk("rst_flush", 32'(flushes()), 32'h3);
        chk("rst_memreq", 32'(mem_req), 32'h0);
        chk("rst_fwd_a", 32'(fwd_a), 32'h0);
        cyc();
        chk("rst_err", 32'(mem_err), 32'h0);
        rst = 1'b0;
        clr();
        cyc();

        for (int i = 0; i < 12; i++) begin
            rs1_D = vt[i].rs1_D; rs2_D = vt[i].rs2_D;
            rs1_EX = vt[i].rs1_EX; rs2_EX = vt[i].rs2_EX;
            rd_EX = vt[i].rd_EX; rsrc = vt[i].rsrc; pc_src = vt[i].pc;
            rd_M = vt[i].rd_M; rw_M = vt[i].rw_M;
            rd_W = vt[i].rd_W; rw_W = vt[i].rw_W;
            #2;
            chk($sformatf("vec%0d_stall", i), 32'(stalls()), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d_flush", i), 32'(flushes()), 32'(vt[i].e_flush));
            chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_a), 32'(vt[i].e_fa));
            chk($sformatf("vec%0d_fwd_b", i), 32'(fwd_b), 32'(vt[i].e_fb));
            cyc();
        end
        clr();
        cyc();

        // ack after three wait cycles
        mem_req_M = 1;
        for (int c = 0; c < 4; c++) begin
            mem_ack = (c == 3);
            #2;
            chk($sformatf("wait%0d_memreq", c), 32'(mem_req), 32'h1);
            chk($sformatf("wait%0d_stall", c), 32'(stalls()), (c < 3) ? 32'hF : 32'h0);
            cyc();
        end
        mem_req_M = 0; mem_ack = 0;
        #2;
        chk("wait_done_memreq", 32'(mem_req), 32'h0);
        chk("wait_done_stall", 32'(stalls()), 32'h0);
        cyc();

        // zero-wait access
        mem_req_M = 1; mem_ack = 1;
        #2;
        chk("zw_stall", 32'(stalls()), 32'h0);
        chk("zw_memreq", 32'(mem_req), 32'h1);
        cyc();
        #2;
        chk("zw2_stall", 32'(stalls()), 32'h0);
        mem_req_M = 0; mem_ack = 0;
        cyc();

        // timeout with MEM_TIMEOUT = 4
        mem_req_M = 1;
        for (int c = 0; c < 5; c++) begin
            #2;
            chk($sformatf("tmo%0d_stall", c), 32'(stalls()), (c < 4) ? 32'hF : 32'h0);
            chk($sformatf("tmo%0d_err", c), 32'(mem_err), 32'h0);
            cyc();
        end
        mem_req_M = 0;
        #2;
        chk("tmo_err_set", 32'(mem_err), 32'h1);
        chk("tmo_idle_memreq", 32'(mem_req), 32'h0);
        cyc();
        mem_req_M = 1; mem_ack = 1;
        #2;
        chk("post_tmo_stall", 32'(stalls()), 32'h0);
        chk("post_tmo_err", 32'(mem_err), 32'h1);
        cyc();
        mem_req_M = 0; mem_ack = 0;
        #2;
        chk("err_sticky", 32'(mem_err), 32'h1);
        cyc();

        // branch flush deferred by memory stall
        mem_req_M = 1; pc_src = 1;
        for (int c = 0; c < 4; c++) begin
            mem_ack = (c == 3);
            #2;
            chk($sformatf("prio%0d_flush", c), 32'(flushes()), (c < 3) ? 32'h0 : 32'h3);
            chk($sformatf("prio%0d_stall", c), 32'(stalls()), (c < 3) ? 32'hF : 32'h0);
            cyc();
        end
        clr();
        cyc();

        // reset pulse on the second wait cycle
        mem_req_M = 1;
        #2;
        chk("rw_first_stall", 32'(stalls()), 32'hF);
        cyc();
        rst = 1'b1;
        #2;
        chk("rw_rst_memreq", 32'(mem_req), 32'h0);
        chk("rw_rst_stall", 32'(stalls()), 32'h0);
        chk("rw_rst_flush", 32'(flushes()), 32'h3);
        cyc();
        rst = 1'b0;
        mem_req_M = 0;
        #2;
        chk("rw_idle_memreq", 32'(mem_req), 32'h0);
        chk("rw_idle_stall", 32'(stalls()), 32'h0);
        chk("rw_err_clr", 32'(mem_err), 32'h0);
`ifdef PIPELINE_CTRL_PERF_EN
        chk("cnt_mstall_clr", cnt_mstall, 32'h0);
        chk("cnt_lu_clr", cnt_lu, 32'h0);
        chk("cnt_flush_clr", cnt_flush, 32'h0);
        chk("cnt_tmo_clr", cnt_tmo, 32'h0);
`endif
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage Osiris I pipeline.
- Drives stall and flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Produces EX-stage operand forwarding selects.
- Sequences the data-memory access of the instruction held in the MEM stage through a request/ack handshake with a wait-state FSM and a timeout.

Parameters:
- REG_WIDTH, 4, register-index width.
- TMO_WIDTH, 8, width of the memory wait/timeout counter.
- MEM_TIMEOUT, 200, maximum WAIT cycles before abort; legal range 1..2^TMO_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_rs1_D, i_rs2_D  in  REG_WIDTH  source registers in DECODE.
- i_rs1_EX, i_rs2_EX, i_rd_EX  in  REG_WIDTH  registers in EXECUTE.
- i_result_src_EX  in  2  2'b01 = load in EXECUTE.
- i_pc_src_EX  in  1  branch/jump taken in EXECUTE.
- i_rd_M  in  REG_WIDTH  destination in MEMORY.
- i_reg_write_M  in  1  MEMORY writes rd.
- i_mem_req_M  in  1  MEMORY holds a load or store.
- i_rd_W  in  REG_WIDTH  destination in WRITEBACK.
- i_reg_write_W  in  1  WRITEBACK writes rd.
- i_mem_ack  in  1  data memory completes the access this cycle.
- o_stall_F, o_stall_D, o_stall_EX, o_stall_M  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- o_flush_D, o_flush_EX  out  1  clear IF/ID, ID/EX.
- o_forward_a_EX, o_forward_b_EX  out  2  00 = regfile, 10 = MEM result, 01 = WB result.
- o_mem_req  out  1  data memory request strobe.
- o_mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset: clock is clk; reset rst is synchronous, active-high.
  - Registered state after reset: FSM = IDLE, wait counter = 0, o_mem_err = 0.
  - While rst = 1, combinational outputs are: all stalls 0, o_flush_D = o_flush_EX = 1, o_mem_req = 0, forwards 00.
- Forwarding (combinational):
  - fwd_a = 10 if i_reg_write_M and i_rd_M != 0 and i_rd_M == i_rs1_EX.
  - Otherwise fwd_a = 01 if the same test holds for W.
  - Otherwise fwd_a = 00. fwd_b is identical using i_rs2_EX.
  - MEM has priority over WB.
- Load-use (combinational): lu = (i_result_src_EX == 01) and i_rd_EX != 0 and (i_rd_EX == i_rs1_D or i_rd_EX == i_rs2_D).
- Memory FSM, states IDLE and WAIT:
  - IDLE with i_mem_req_M = 1: o_mem_req = 1.
    - If i_mem_ack is high in the same cycle, the access has zero wait and there is no stall; stay IDLE.
    - Otherwise mstall = 1, go to WAIT, counter = 1.
  - WAIT: o_mem_req = 1, mstall = 1.
    - On i_mem_ack: mstall = 0 in that cycle; go to IDLE, counter = 0.
    - If no ack and counter == MEM_TIMEOUT: set o_mem_err, mstall = 0, go to IDLE. The access is abandoned and the pipeline advances.
    - Otherwise counter increments; it never wraps.
  - i_mem_req_M dropping while in WAIT is illegal (it cannot happen because EX/MEM is held). The FSM ignores it.
- Priority (highest first):
  1. mstall: all four stalls = 1, no flushes. A pending branch flush is deferred until release; i_pc_src_EX stays valid because ID/EX is held.
  2. i_pc_src_EX: o_flush_D = o_flush_EX = 1, no stalls.
  3. lu: o_stall_F = o_stall_D = 1, o_flush_EX = 1.
  4. Otherwise everything is 0.
- Latency:
  - Stall, flush and forward outputs are combinational, with 0-cycle latency.
  - FSM and counter update on posedge clk.
- Reset mid-WAIT: FSM returns to IDLE the next edge, the counter clears, o_mem_err clears, and o_mem_req drops immediately.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- Enabled adds four outputs:
  - o_cnt_mstall  out  32: cycles with mstall = 1.
  - o_cnt_lu  out  32: load-use bubbles.
  - o_cnt_flush  out  32: taken-branch flushes.
  - o_cnt_tmo  out  32: timeouts.
  - All counters reset to 0, saturate at all-ones and are counted only when not in rst.
- Disabled: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Forwarding: rd_M = 5, reg_write_M = 1, rd_W = 5, reg_write_W = 1, rs1_EX = 5, rs2_EX = 0 -> fwd_a = 10, fwd_b = 00. Then rd_M = 0 -> fwd_a = 01.
- Load-use: result_src_EX = 01, rd_EX = 3, rs2_D = 3 -> stall_F = stall_D = flush_EX = 1 for exactly one cycle. The same setup with rd_EX = 0 -> no stall.
- Memory wait: mem_req_M = 1, ack delayed 3 cycles -> mem_req high for 4 cycles, all stalls high for 3 cycles, and stalls low in the ack cycle. Zero-wait ack -> no stall.
- Timeout: MEM_TIMEOUT = 4, no ack -> stalls released after cycle 4 and o_mem_err = 1 sticky. A later access with immediate ack is normal, and o_mem_err stays 1 until rst.
- Priority: mstall active together with pc_src_EX = 1 -> no flush during the wait; flush_D = flush_EX = 1 in the ack cycle.
- Reset in WAIT: rst pulsed for 1 cycle on the 2nd wait cycle -> mem_req = 0, stalls = 0, flushes = 1 during rst; FSM is IDLE afterward. With PIPELINE_CTRL_PERF_EN, counters read 0.
